// File: rtl/sevenseg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with a shadow digit file that is
// copied to the displayed set only at frame boundaries, so updates never tear.
module sevenseg_scan_ctrl #(
    parameter int unsigned N_DIGITS       = 4,
    parameter int unsigned PRESCALE       = 3000,
    parameter int unsigned BLANK          = 60,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [1:0]          wr_digit,
    input  logic [4:0]          wr_data,
    input  logic                wr_dp,
    input  logic                commit,
    output logic [6:0]          segment,
    output logic                dp,
    output logic [N_DIGITS-1:0] enable,
    output logic                frame_done,
    output logic                commit_pending
);

    localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned DW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int unsigned EW = 6;
    localparam logic [6:0]    SEG_OFF     = {7{SEG_ACTIVE_LOW}};
    // Entry layout: {blank, hex[3:0], dp}
    localparam logic [EW-1:0] ENTRY_BLANK = 6'b1_0000_0;

    logic [EW-1:0]       shadow_q [N_DIGITS];
    logic [EW-1:0]       shadow_d [N_DIGITS];
    logic [EW-1:0]       active_q [N_DIGITS];
    logic [EW-1:0]       active_d [N_DIGITS];
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [DW-1:0]       digit_q, digit_d;
    logic                pending_d;
    logic                frame_done_d;
    logic                slot_end, frame_end;
    logic [N_DIGITS-1:0] enable_d;
    logic [6:0]          segment_d;
    logic                dp_d;
    logic [EW-1:0]       entry;

    function automatic logic [6:0] decode(input logic [3:0] hex);
        logic [6:0] seg;
        case (hex)
            4'h0: seg = 7'h3F;  4'h1: seg = 7'h06;  4'h2: seg = 7'h5B;  4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;  4'h5: seg = 7'h6D;  4'h6: seg = 7'h7D;  4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;  4'h9: seg = 7'h6F;  4'hA: seg = 7'h77;  4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;  4'hD: seg = 7'h5E;  4'hE: seg = 7'h79;  default: seg = 7'h71;
        endcase
        return seg;
    endfunction

    assign wr_ready  = !commit_pending && !sys_rst;
    assign slot_end  = (cnt_q == CW'(PRESCALE - 1));
    assign frame_end = slot_end && (digit_q == DW'(N_DIGITS - 1));

    // State register
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt_q          <= '0;
            digit_q        <= '0;
            commit_pending <= 1'b0;
            frame_done     <= 1'b0;
            enable         <= '0;
            segment        <= SEG_OFF;
            dp             <= SEG_ACTIVE_LOW;
            for (int unsigned i = 0; i < N_DIGITS; i++) begin
                shadow_q[i] <= ENTRY_BLANK;
                active_q[i] <= ENTRY_BLANK;
            end
        end else begin
            cnt_q          <= cnt_d;
            digit_q        <= digit_d;
            commit_pending <= pending_d;
            frame_done     <= frame_done_d;
            enable         <= enable_d;
            segment        <= segment_d;
            dp             <= dp_d;
            shadow_q       <= shadow_d;
            active_q       <= active_d;
        end
    end

    // Next state: scan counters, shadow writes, commit at the frame boundary
    always_comb begin
        cnt_d     = slot_end ? '0 : cnt_q + CW'(1);
        digit_d   = digit_q;
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = commit_pending || commit;
        if (slot_end) begin
            digit_d = (digit_q == DW'(N_DIGITS - 1)) ? '0 : digit_q + DW'(1);
        end
        if (wr_valid && wr_ready) begin
            for (int unsigned i = 0; i < N_DIGITS; i++) begin
                if (wr_digit == 2'(i)) begin
                    shadow_d[i] = {wr_data, wr_dp};
                end
            end
        end
        // A same-cycle write is part of the copied set
        if (frame_end) begin
            if (pending_d) begin
                active_d = shadow_d;
            end
            pending_d = 1'b0;
        end
        frame_done_d = (cnt_d == CW'(PRESCALE - 1)) && (digit_d == DW'(N_DIGITS - 1));
    end

    // Output decode from the current slot phase, registered one cycle later
    always_comb begin
        enable_d  = '0;
        segment_d = SEG_OFF;
        dp_d      = SEG_ACTIVE_LOW;
        entry     = active_q[digit_q];
        if (cnt_q >= CW'(BLANK)) begin
            enable_d = N_DIGITS'(1) << digit_q;
            if (!entry[5]) begin
                segment_d = decode(entry[4:1]) ^ SEG_OFF;
                dp_d      = entry[0] ^ SEG_ACTIVE_LOW;
            end
        end
    end

endmodule

// File: doc/sevenseg_scan_ctrl.md
Name: sevenseg_scan_ctrl

Overview:
- Time-multiplexed seven-segment display controller for iCE40 boards with shared segment lines and per-digit enables.
- Holds a shadow digit register file, written over a valid/ready port. A commit pulse makes the shadow contents visible at the next frame boundary, so a display update never tears mid-frame.
- Scans the digits round-robin, inserting a blanking interval between digits to suppress ghosting.
- Sits between system logic and the board pads: segment/dp/enable outputs go straight to the top-level sevenseg pins.

Parameters:
- N_DIGITS, 4, number of multiplexed digits; legal 1..4.
- PRESCALE, 3000, sys_clk cycles per digit slot; at 12 MHz this is 4 kHz per slot. Must be greater than BLANK.
- BLANK, 60, cycles at the start of each slot with all enables and segments inactive.
- SEG_ACTIVE_LOW, 1, 1 = segment and dp pins drive low to light; enables are always active-high.

Ports:
- sys_clk  in  1  sole clock.
- sys_rst  in  1  reset.
- wr_valid  in  1  write request.
- wr_ready  out  1  controller accepts the write this cycle.
- wr_digit  in  2  digit index; 0 is the rightmost digit.
- wr_data  in  5  bit4 = blank digit, bits3:0 = hex value.
- wr_dp  in  1  decimal point lit.
- commit  in  1  single-cycle pulse requesting shadow-to-active copy.
- segment  out  7  bit0 = a … bit6 = g; physical pin level.
- dp  out  1  decimal point; physical pin level.
- enable  out  N_DIGITS  one-hot digit enable, active-high.
- frame_done  out  1  one-cycle pulse at the end of each full scan.
- commit_pending  out  1  a commit is waiting for the frame boundary.

Behaviour:
- Clock and reset: one clock, sys_clk. Reset sys_rst is synchronous and active-high.
- Values after reset:
  - Outputs: enable=0, segment and dp inactive level (all 1 when SEG_ACTIVE_LOW=1), frame_done=0, commit_pending=0, wr_ready=0 while sys_rst=1 and 1 from the first cycle after.
  - Internal state: shadow and active entries all blank (bit4=1, dp=0); slot counter cnt=0; digit=0.
- Write handshake:
  - A transfer occurs when wr_valid && wr_ready.
  - The shadow entry [wr_digit] is updated at that edge.
  - wr_digit >= N_DIGITS: handshake completes, data is discarded.
  - wr_ready = !commit_pending && !sys_rst.
- Commit:
  - A commit pulse sets commit_pending.
  - A commit while commit_pending is already 1 has no additional effect.
  - A write and a commit in the same cycle: the write lands in shadow and is included in the commit.
- Scan counter:
  - cnt counts 0..PRESCALE-1 per slot.
  - At cnt==PRESCALE-1, cnt wraps to 0 and digit increments, wrapping N_DIGITS-1 to 0.
- Slot phases:
  - BLANK when cnt < BLANK.
  - SHOW otherwise.
- Frame boundary:
  - frame_done=1 exactly in the cycle where cnt==PRESCALE-1 and digit==N_DIGITS-1.
  - At that edge, if commit_pending, all active entries are copied from shadow and commit_pending clears.
  - A commit arriving in the frame_done cycle itself is applied at that same edge.
- Outputs:
  - Registered: values at edge k reflect the phase/digit computed from cnt/digit before edge k, i.e. one cycle of latency.
  - SHOW: enable = one-hot(digit); segment = decode(active[digit]); dp = active dp.
  - BLANK: enable=0, segments and dp inactive.
  - A blank entry in SHOW: enable asserted, segments and dp inactive.
- Decode table (logical, a=bit0), gfedcba order:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - Pin level = logical XOR {7{SEG_ACTIVE_LOW}}.
- Invariants:
  - At most one enable bit high in any cycle.
  - enable is never high while cnt < BLANK (allowing for the one-cycle output latency).
- Reset mid-operation: returns to the reset state at the next edge. Pending commit, shadow and active contents are all lost.

Test Plan:
Bench parameters: N_DIGITS=4, PRESCALE=8, BLANK=2, SEG_ACTIVE_LOW=1.
- Reset release -> enable=0000, segment=7F and dp=1 throughout the first frame; first frame_done pulse at cycle 32 after release; wr_ready=1 from cycle 1.
- Write digit0=4'h8 with dp=1, digit3=4'h1, then commit mid-frame -> commit_pending=1, wr_ready=0 until the frame_done edge. Next frame: enable=0001 shows segment=00, dp=0; enable=1000 shows segment=79; digits 1 and 2 stay dark.
- Write during the commit_pending window with wr_valid held -> no transfer until commit_pending clears; the write completes the cycle after.
- Commit asserted in the frame_done cycle -> new values visible in digit 0 of the immediately following frame.
- wr_digit=3 with wr_data=5'h1F (blank), plus commit -> enable=1000 asserted with segment=7F; enable is never high during the 2 blank cycles of any slot.
- Assert sys_rst for 1 cycle mid-SHOW -> next edge gives enable=0 and segment=7F; active contents blank; commit_pending=0.
